// File: rtl/msrv32_regfile_scoreboard.sv
// Integer register file with two combinational read ports, one writeback
// port and a per-register pending-write scoreboard for hazard detection.
module msrv32_regfile_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  parameter int CW       = 6
) (
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_in,
  input  logic [AW-1:0]   rs_1_addr_in,
  input  logic [AW-1:0]   rs_2_addr_in,
  output logic [XLEN-1:0] rs_1_out,
  output logic [XLEN-1:0] rs_2_out,
  output logic            rs_1_busy_out,
  output logic            rs_2_busy_out,
  input  logic            iss_en_in,
  input  logic [AW-1:0]   iss_rd_addr_in,
  input  logic            wr_en_in,
  input  logic [AW-1:0]   rd_addr_in,
  input  logic [XLEN-1:0] rd_in,
  input  logic            flush_in,
  output logic [CW-1:0]   busy_cnt_out
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;
  logic             wr_ok;
  logic             iss_ok;

  // Address is in range and not the hardwired zero register.
  function automatic logic writable(input logic [AW-1:0] a);
    logic in_rng;
    in_rng = 32'(a) < 32'(NREGS);
    return in_rng && !(ZERO_REG != 0 && a == '0);
  endfunction

  assign wr_ok  = wr_en_in && !ms_riscv32_mp_rst_in
               && writable(rd_addr_in);
  assign iss_ok = iss_en_in && writable(iss_rd_addr_in);

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            b;
    assign a = (p == 0) ? rs_1_addr_in : rs_2_addr_in;
    always_comb begin
      d = '0;
      b = 1'b0;
      if (writable(a)) begin
        if (BYPASS != 0 && wr_ok && a == rd_addr_in) begin
          d = rd_in;
        end else begin
          d = regs_q[a];
          b = pend_q[a];
        end
      end
    end
  end

  assign rs_1_out      = g_rd[0].d;
  assign rs_2_out      = g_rd[1].d;
  assign rs_1_busy_out = g_rd[0].b;
  assign rs_2_busy_out = g_rd[1].b;

  // Issue is applied last so a new producer supersedes a retiring one.
  always_comb begin
    pend_d = pend_q;
    if (flush_in) begin
      pend_d = '0;
    end else begin
      if (wr_ok)  pend_d[rd_addr_in]     = 1'b0;
      if (iss_ok) pend_d[iss_rd_addr_in] = 1'b1;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) pend_q <= '0;
    else                      pend_q <= pend_d;
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[rd_addr_in] <= rd_in;
    end
  end

  always_comb begin
    busy_cnt_out = '0;
    for (int i = 0; i < NREGS; i++) begin
      busy_cnt_out = busy_cnt_out + CW'(pend_q[i]);
    end
  end

endmodule

// File: tb/tb_msrv32_regfile_scoreboard.sv
// Bench for msrv32_regfile_scoreboard: three configurations share one
// stimulus stream and are checked against an array-based model.
module tb_msrv32_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  ra1 = '0, ra2 = '0, ia = '0, wa = '0;
  logic        ie = 1'b0, we = 1'b0, fl = 1'b0;
  logic [31:0] wd = '0;

  logic [31:0] o1 [3];
  logic [31:0] o2 [3];
  logic        ob1 [3];
  logic        ob2 [3];
  logic [5:0]  ca;
  logic [4:0]  cb;
  logic [3:0]  cc;

  int total = 0;
  int bad   = 0;

  int NR  [3] = '{32, 16, 12};
  int MSK [3] = '{31, 15, 15};
  bit BY  [3] = '{1'b1, 1'b0, 1'b1};
  bit ZR  [3] = '{1'b1, 1'b0, 1'b1};

  logic [31:0] mreg  [3][32];
  bit          mpend [3][32];
  bit          mok = 1'b0;

  always #5 clk = ~clk;

  msrv32_regfile_scoreboard u_a (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
    .rs_1_addr_in(ra1), .rs_2_addr_in(ra2),
    .rs_1_out(o1[0]), .rs_2_out(o2[0]),
    .rs_1_busy_out(ob1[0]), .rs_2_busy_out(ob2[0]),
    .iss_en_in(ie), .iss_rd_addr_in(ia),
    .wr_en_in(we), .rd_addr_in(wa), .rd_in(wd),
    .flush_in(fl), .busy_cnt_out(ca));

  msrv32_regfile_scoreboard #(
    .XLEN(32), .NREGS(16), .AW(4), .BYPASS(0), .ZERO_REG(0), .CW(5)
  ) u_b (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
    .rs_1_addr_in(ra1[3:0]), .rs_2_addr_in(ra2[3:0]),
    .rs_1_out(o1[1]), .rs_2_out(o2[1]),
    .rs_1_busy_out(ob1[1]), .rs_2_busy_out(ob2[1]),
    .iss_en_in(ie), .iss_rd_addr_in(ia[3:0]),
    .wr_en_in(we), .rd_addr_in(wa[3:0]), .rd_in(wd),
    .flush_in(fl), .busy_cnt_out(cb));

  msrv32_regfile_scoreboard #(
    .XLEN(32), .NREGS(12), .AW(4), .BYPASS(1), .ZERO_REG(1), .CW(4)
  ) u_c (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
    .rs_1_addr_in(ra1[3:0]), .rs_2_addr_in(ra2[3:0]),
    .rs_1_out(o1[2]), .rs_2_out(o2[2]),
    .rs_1_busy_out(ob1[2]), .rs_2_busy_out(ob2[2]),
    .iss_en_in(ie), .iss_rd_addr_in(ia[3:0]),
    .wr_en_in(we), .rd_addr_in(wa[3:0]), .rd_in(wd),
    .flush_in(fl), .busy_cnt_out(cc));

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] act_cnt(input int k);
    case (k)
      0:       return ca;
      1:       return 6'(cb);
      default: return 6'(cc);
    endcase
  endfunction

  function automatic bit wable(input int k, input int a);
    return a < NR[k] && !(ZR[k] && a == 0);
  endfunction

  function automatic bit wok(input int k);
    return we && !rst && wable(k, int'(wa) & MSK[k]);
  endfunction

  function automatic logic [32:0] pred(input int k, input int a);
    if (!wable(k, a)) return '0;
    if (BY[k] && wok(k) && a == (int'(wa) & MSK[k]))
      return {1'b0, wd};
    return {mpend[k][a], mreg[k][a]};
  endfunction

  function automatic int popc(input int k);
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(mpend[k][i]);
    return n;
  endfunction

  // Check against the model, then advance it by the coming clock edge.
  always @(negedge clk) begin
    if (mok) begin
      for (int k = 0; k < 3; k++) begin
        logic [32:0] p1, p2;
        p1 = pred(k, int'(ra1) & MSK[k]);
        p2 = pred(k, int'(ra2) & MSK[k]);
        chk($sformatf("i%0d_rs1", k), o1[k], p1[31:0]);
        chk($sformatf("i%0d_rs2", k), o2[k], p2[31:0]);
        chk($sformatf("i%0d_b1", k), 32'(ob1[k]), 32'(p1[32]));
        chk($sformatf("i%0d_b2", k), 32'(ob2[k]), 32'(p2[32]));
        chk($sformatf("i%0d_cnt", k), 32'(act_cnt(k)), 32'(popc(k)));
      end
    end
    for (int k = 0; k < 3; k++) begin
      int w, s;
      w = int'(wa) & MSK[k];
      s = int'(ia) & MSK[k];
      if (rst) begin
        for (int i = 0; i < 32; i++) begin
          mreg[k][i]  = '0;
          mpend[k][i] = 1'b0;
        end
      end else begin
        if (wok(k)) mreg[k][w] = wd;
        if (fl) begin
          for (int i = 0; i < 32; i++) mpend[k][i] = 1'b0;
        end else begin
          if (wok(k)) mpend[k][w] = 1'b0;
          if (ie && wable(k, s)) mpend[k][s] = 1'b1;
        end
      end
    end
    if (rst) mok = 1'b1;
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic nw;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) cyc;
    rst = 1'b0;

    for (int r = 1; r < 16; r++) begin
      we = 1'b1; wa = 5'(r); wd = 32'(r) * 32'h01010101;
      ie = (r % 3 == 0); ia = 5'(r);
      cyc;
    end
    rst = 1'b1; we = 1'b1; wa = 5'd5; wd = 32'd123;
    ie = 1'b1; ia = 5'd6; ra1 = 5'd5; ra2 = 5'd3;
    cyc;
    nw;
    chk("rst_rs1", o1[0], 32'h0);
    chk("rst_rs2", o2[0], 32'h0);
    chk("rst_cnt", 32'(ca), 32'h0);
    chk("rst_cntB", 32'(cb), 32'h0);
    cyc;
    rst = 1'b0; we = 1'b0; ie = 1'b0;
    cyc;

    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra1 = 5'd5;
    nw;
    chk("byp_A", o1[0], 32'hDEADBEEF);
    chk("nobyp_B_old", o1[1], 32'h0);
    cyc;
    we = 1'b0;
    nw;
    chk("nobyp_B_new", o1[1], 32'hDEADBEEF);
    chk("A_after", o1[0], 32'hDEADBEEF);
    cyc;

    ie = 1'b1; ia = 5'd7;
    cyc;
    ia = 5'd9;
    nw;
    chk("sb_cnt1", 32'(ca), 32'd1);
    cyc;
    ie = 1'b0; ra2 = 5'd9;
    nw;
    chk("sb_cnt2", 32'(ca), 32'd2);
    chk("sb_b2", 32'(ob2[0]), 32'd1);
    cyc;
    we = 1'b1; wa = 5'd7; wd = 32'h11;
    cyc;
    we = 1'b0;
    nw;
    chk("sb_wb_cnt", 32'(ca), 32'd1);
    cyc;
    fl = 1'b1; ie = 1'b1; ia = 5'd3;
    cyc;
    fl = 1'b0; ie = 1'b0; ra1 = 5'd3;
    nw;
    chk("fl_cnt", 32'(ca), 32'd0);
    chk("fl_b1", 32'(ob1[0]), 32'd0);
    cyc;

    ie = 1'b1; ia = 5'd12;
    cyc;
    we = 1'b1; wa = 5'd12; wd = 32'h55;
    nw;
    chk("x12_pre_cnt", 32'(ca), 32'd1);
    cyc;
    ie = 1'b0; we = 1'b0; ra1 = 5'd12;
    nw;
    chk("x12_data", o1[0], 32'h55);
    chk("x12_busy", 32'(ob1[0]), 32'd1);
    chk("x12_cnt", 32'(ca), 32'd1);
    cyc;

    fl = 1'b1;
    cyc;
    fl = 1'b0; we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF;
    ie = 1'b1; ia = 5'd0; ra1 = 5'd0;
    nw;
    chk("x0_byp", o1[0], 32'h0);
    chk("x0_busy", 32'(ob1[0]), 32'd0);
    cyc;
    we = 1'b0; ie = 1'b0;
    nw;
    chk("x0_data", o1[0], 32'h0);
    chk("x0_cnt", 32'(ca), 32'd0);
    chk("x0_B_data", o1[1], 32'hFFFFFFFF);
    chk("x0_B_cnt", 32'(cb), 32'd1);
    cyc;

    fl = 1'b1;
    cyc;
    fl = 1'b0;
    for (int r = 1; r < 16; r++) begin
      ie = 1'b1; ia = 5'(r);
      cyc;
    end
    ie = 1'b0;
    nw;
    chk("full_cntB", 32'(cb), 32'd15);
    cyc;
    for (int r = 1; r < 16; r++) begin
      we = 1'b1; wa = 5'(r); wd = 32'h1000 + 32'(r);
      cyc;
    end
    we = 1'b0;
    nw;
    chk("empty_cntB", 32'(cb), 32'd0);
    for (int r = 1; r < 16; r++) begin
      ra1 = 5'(r);
      nw;
      chk($sformatf("rdB_x%0d", r), o1[1], 32'h1000 + 32'(r));
    end
    cyc;

    repeat (4000) begin
      rst = ($urandom_range(0, 96) == 0);
      fl  = ($urandom_range(0, 12) == 0);
      ie  = 1'($urandom);
      we  = 1'($urandom);
      ia  = 5'($urandom_range(0, 31));
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      ra1 = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom);
      ra2 = ($urandom_range(0, 1) == 0) ? ia : 5'($urandom);
      cyc;
    end
    rst = 1'b0; fl = 1'b0; ie = 1'b0; we = 1'b0;
    nw;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/msrv32_regfile_scoreboard.md
Name: msrv32_regfile_scoreboard

Overview:
- Parametrised integer register file with a per-register pending-write scoreboard for the multi-stage pipeline.
- Two combinational read ports and one synchronous writeback port, with optional same-cycle write-to-read bypass.
- Issue marks a destination register busy; writeback or flush clears it.
- Decode uses the busy flags and busy count for hazard stalls instead of relying on bypass alone.

Parameters:
- XLEN, 32: data width of each register.
- NREGS, 32: number of architectural registers, 2..2^AW.
- AW, 5: register address width; must equal clog2(NREGS).
- BYPASS, 1: 1 = a same-cycle writeback is forwarded to the read ports; 0 = reads return stored state only.
- ZERO_REG, 1: 1 = register 0 is hardwired to zero and never busy; 0 = register 0 is an ordinary register.
- CW, 6: width of busy_cnt_out; must equal clog2(NREGS+1).

Ports:
- ms_riscv32_mp_clk_in  input  1  single clock, all state updates on its rising edge
- ms_riscv32_mp_rst_in  input  1  synchronous, active-high reset
- rs_1_addr_in  input  AW  read port 1 address
- rs_2_addr_in  input  AW  read port 2 address
- rs_1_out  output  XLEN  read port 1 data
- rs_2_out  output  XLEN  read port 2 data
- rs_1_busy_out  output  1  register addressed by port 1 has a pending write
- rs_2_busy_out  output  1  register addressed by port 2 has a pending write
- iss_en_in  input  1  issue strobe: mark iss_rd_addr_in pending
- iss_rd_addr_in  input  AW  issue destination address
- wr_en_in  input  1  writeback strobe
- rd_addr_in  input  AW  writeback address
- rd_in  input  XLEN  writeback data
- flush_in  input  1  clear every pending bit
- busy_cnt_out  output  CW  number of registers currently pending

Behaviour:
- Reset (sampled at clock edge only):
  - All registers are set to 0 and all pending bits cleared.
  - Consequently rs_*_out = 0, rs_*_busy_out = 0 and busy_cnt_out = 0 from the first edge with reset high.
  - Reset overrides issue, writeback and flush in the same cycle.
  - Reset asserted mid-operation discards all pending state.
- Read ports are purely combinational from stored state, with zero latency.
- Valid address: addr < NREGS. An invalid address reads data 0 and busy 0. Writes and issues to an invalid address are ignored.
- ZERO_REG = 1 (addr 0):
  - Reads return 0 with busy 0.
  - Writes and issues to address 0 are ignored.
  - Bypass never applies to address 0.
- Write condition: wr_en_in high, valid rd_addr_in, and not (ZERO_REG and rd_addr_in = 0). When met, reg[rd_addr_in] <= rd_in at the edge.
- Bypass (BYPASS = 1, write condition true, rs_x_addr_in = rd_addr_in): rs_x_out = rd_in and rs_x_busy_out = 0 in the same cycle. Both ports may bypass simultaneously.
- BYPASS = 0: the written value is visible the cycle after the edge, and busy drops the cycle after the edge.
- Pending bit next-state, per register r, in priority order:
  1. Reset: clear.
  2. flush_in: clear. Any issue in the same cycle is ignored.
  3. Issue to r (iss_en_in, valid address, not hardwired zero): set. This wins over a writeback to r in the same cycle, because the new producer supersedes the old one; the writeback data is still written.
  4. Writeback to r (write condition true): clear.
  5. Otherwise: hold.
- Writeback to a register that is not pending is legal: data is written and the pending bit stays 0.
- Repeated issue to an already-pending register keeps it pending. No count per register is kept.
- busy_cnt_out is the combinational popcount of the registered pending vector; range 0..NREGS, no wrap.
- Writeback data during flush is still written.

Test Plan:
- Reset with all registers preloaded: on the edge with ms_riscv32_mp_rst_in = 1, rs_1_out = rs_2_out = 0 and busy_cnt_out = 0, even with wr_en_in = 1 and iss_en_in = 1 asserted that cycle.
- Write 0xDEADBEEF to x5 while rs_1_addr_in = 5:
  - BYPASS = 1: rs_1_out = 0xDEADBEEF in the same cycle.
  - BYPASS = 0: old value in the same cycle, 0xDEADBEEF the next cycle.
- Scoreboard sequence:
  - Issue x7 then x9 -> busy_cnt_out goes 1, then 2; rs_2_busy_out = 1 with rs_2_addr_in = 9.
  - Writeback x7 = 0x11 -> busy_cnt_out = 1 after the edge.
  - flush_in together with issue x3 -> busy_cnt_out = 0 and x3 not busy.
- Same-cycle issue and writeback to x12 with rd_in = 0x55 -> x12 reads 0x55 and stays busy; busy_cnt_out is unchanged.
- ZERO_REG = 1: write 0xFFFFFFFF to x0 and issue x0 -> x0 reads 0, never busy, busy_cnt_out = 0. ZERO_REG = 0: x0 reads 0xFFFFFFFF.
- NREGS = 16, AW = 4, CW = 5: issue all 15 valid non-zero registers -> busy_cnt_out = 15. Writeback all of them -> busy_cnt_out = 0, with each read returning its written value.
